load_store_unit: RTL

Multicycle data-memory stage for the RISC-V core. It sits directly downstream of the control unit and consumes its memory-phase controls (`Mem_Write`, `Store_type`, `Load_type`), plus the ALU-computed address and the rs2 store data. It holds a word-organised data RAM, performs `sw`/`sb` stores and `lw`/`lbu` loads over a fixed number of wait cycles, and returns the loaded value with a one-cycle completion pulse that the control unit uses to leave its Memory state.

---
 rtl/load_store_unit.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Multicycle data-memory stage: word RAM with sw/sb stores and lw/lbu loads.
// Define LSU_MEM_CLEAR_EN to have RST asynchronously clear the whole RAM.
module load_store_unit #(
    parameter int ADDR_W = 8,
    parameter int LAT    = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Start,
    input  logic              Mem_Write,
    input  logic              Store_type,
    input  logic              Load_type,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [31:0]       WData,
    output logic [31:0]       RData,
    output logic              Busy,
    output logic              Done,
    output logic              Err
);

    localparam int WORDS = 2 ** (ADDR_W - 2);
    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_COMMIT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [ADDR_W-1:0]  addr_q;
    logic [31:0]        wdata_q;
    logic               wr_q;
    logic               sw_q;
    logic               lbu_q;

    logic [31:0]        rdata_q;
    logic               done_q;
    logic               err_q;

    logic [31:0]        mem [WORDS];

    logic [ADDR_W-3:0]  word_idx;
    logic [1:0]         lane;
    logic [4:0]         lane_sh;
    logic [31:0]        rd_word;
    logic [7:0]         rd_byte;
    logic               word_op;
    logic               misalign;
    logic               commit;
    logic               mem_we;
    logic               ld_ok;
    logic [3:0]         be;
    logic [31:0]        wr_data;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_W'(LAT - 1);
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_COMMIT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_COMMIT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request is latched once; inputs are free to change afterwards.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            sw_q    <= 1'b0;
            lbu_q   <= 1'b0;
        end else if (state_q == S_IDLE && Start) begin
            addr_q  <= Addr;
            wdata_q <= WData;
            wr_q    <= Mem_Write;
            sw_q    <= Store_type;
            lbu_q   <= Load_type;
        end
    end

    assign word_idx = addr_q[ADDR_W-1:2];
    assign lane     = addr_q[1:0];
    assign lane_sh  = {lane, 3'b000};
    assign rd_word  = mem[word_idx];
    assign rd_byte  = 8'(rd_word >> lane_sh);

    assign word_op  = wr_q ? sw_q : ~lbu_q;
    assign misalign = word_op && (lane != 2'b00);
    assign commit   = (state_q == S_COMMIT);
    assign mem_we   = commit && wr_q && !misalign;
    assign ld_ok    = commit && !wr_q && !misalign;

    // sb replicates the byte onto all lanes and enables only one.
    assign be       = sw_q ? 4'b1111 : (4'b0001 << lane);
    assign wr_data  = sw_q ? wdata_q : {4{wdata_q[7:0]}};

`ifdef LSU_MEM_CLEAR_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int w = 0; w < WORDS; w++) begin
                mem[w] <= '0;
            end
        end else if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end
`else
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= commit;
            err_q  <= commit && misalign;
            if (ld_ok) begin
                rdata_q <= lbu_q ? {24'b0, rd_byte} : rd_word;
            end
        end
    end

    assign RData = rdata_q;
    assign Busy  = (state_q != S_IDLE);
    assign Done  = done_q;
    assign Err   = err_q;

endmodule
